// File: rtl/cac_uart_transmitter.sv
// CAC UART transmitter: byte FIFO feeding a start/8 data (MSB first)/stop serialiser.
// Line output and frame_done are registered; the line returns high asynchronously on reset.
module cac_uart_transmitter #(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUDRATE        = 115_200,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          cac_uart_tx,
  output logic                          tx_busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / BAUDRATE;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW+1)'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("CLOCK_FREQUENCY / BAUDRATE must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_stop_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_done;

  logic w_push, w_pop, w_empty, w_bit_end, w_stop_last;

  assign tx_ready    = (r_count != FIFO_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = tx_valid && tx_ready;
  assign w_bit_end   = (r_cnt == '0);
  assign w_stop_last = (r_stop_idx == 1'(STOP_BITS - 1));
  // Pops happen only from IDLE or on the last cycle of the stop period.
  assign w_pop       = !w_empty &&
                       ((r_state == StIdle) || (r_state == StStop && w_bit_end && w_stop_last));

  assign fifo_level  = r_count;
  assign cac_uart_tx = r_tx;
  assign tx_busy     = (r_state != StIdle);
  assign frame_done  = r_done;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_cnt   <= CNT_RELOAD;
            r_tx    <= 1'b0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_cnt     <= CNT_RELOAD;
            r_bit_idx <= '0;
            r_tx      <= r_shift[7];
            r_state   <= StData;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_cnt <= CNT_RELOAD;
            if (r_bit_idx == 3'd7) begin
              r_tx       <= 1'b1;
              r_stop_idx <= 1'b0;
              r_state    <= StStop;
            end else begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_tx      <= r_shift[6];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StStop: begin
          // Raise frame_done one edge early so it covers the final stop cycle.
          if (r_cnt == CW'(1) && w_stop_last) r_done <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= CNT_RELOAD;
            if (!w_stop_last) begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end else if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_tx    <= 1'b0;
              r_state <= StStart;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cac_uart_transmitter.sv
// Directed bench for cac_uart_transmitter: one 1-stop-bit and one 2-stop-bit instance,
// both at 10 clocks per bit with a 4-entry FIFO.
module tb_cac_uart_transmitter;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, cac_uart_tx, tx_busy, frame_done;
  logic       tx_ready2, tx2, busy2, done2;
  logic [2:0] fifo_level, level2;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cac_uart_transmitter #(
    .CLOCK_FREQUENCY(100_000_000), .BAUDRATE(10_000_000), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cac_uart_tx(cac_uart_tx), .tx_busy(tx_busy), .frame_done(frame_done),
    .fifo_level(fifo_level)
  );

  cac_uart_transmitter #(
    .CLOCK_FREQUENCY(100_000_000), .BAUDRATE(10_000_000), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .cac_uart_tx(tx2), .tx_busy(busy2), .frame_done(done2), .fifo_level(level2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one frame from offset k0 after the start-bit fall, checking every cycle.
  task automatic run_frame(input bit sel, input logic [7:0] exp_byte, input int k0,
                           input string name, output bit next_low);
    int f, bi, bad_bits, bad_done, bad_busy;
    logic [7:0] dec;
    logic exp_bit, line;
    f = (sel ? 11 : 10) * CPB;
    bad_bits = 0; bad_done = 0; bad_busy = 0; dec = '0;
    for (int k = k0; k < f; k++) begin
      if (k > k0) tick();
      line = sel ? tx2 : cac_uart_tx;
      if (k < CPB) exp_bit = 1'b0;
      else if (k < 9 * CPB) begin
        bi = 8 - k / CPB;
        exp_bit = exp_byte[3'(bi)];
      end else exp_bit = 1'b1;
      if (line !== exp_bit) bad_bits++;
      if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2) dec = {dec[6:0], line};
      if ((sel ? done2 : frame_done) !== (k == f - 1)) bad_done++;
      if ((sel ? busy2 : tx_busy) !== 1'b1) bad_busy++;
    end
    tick();
    next_low = ((sel ? tx2 : cac_uart_tx) === 1'b0);
    n_checks++;
    if (dec !== exp_byte) $display("FAIL %s decode: got %h want %h", name, dec, exp_byte);
    else n_pass++;
    n_checks++;
    if (bad_bits != 0) $display("FAIL %s line: %0d wrong cycles, want 0", name, bad_bits);
    else n_pass++;
    n_checks++;
    if (bad_done != 0) $display("FAIL %s frame_done: %0d wrong cycles, want 0", name, bad_done);
    else n_pass++;
    n_checks++;
    if (bad_busy != 0) $display("FAIL %s tx_busy: %0d low cycles, want 0", name, bad_busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    #22;
    n_checks++;
    if ({cac_uart_tx, tx_ready, tx_busy, frame_done, fifo_level} !== 7'b1100_000)
      $display("FAIL reset outputs: got tx=%b rdy=%b busy=%b done=%b lvl=%0d want 1 1 0 0 0",
               cac_uart_tx, tx_ready, tx_busy, frame_done, fifo_level);
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_line_idle();
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (cac_uart_tx !== 1'b1 || frame_done !== 1'b0 || tx2 !== 1'b1 || done2 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL line_idle: %0d active cycles, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_single();
    bit nl;
    tx_data = 8'h10; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd1 || cac_uart_tx !== 1'b1)
      $display("FAIL single accept: got lvl=%0d tx=%b want 1 1", fifo_level, cac_uart_tx);
    else n_pass++;
    tick();
    n_checks++;
    if (fifo_level !== 3'd0 || cac_uart_tx !== 1'b0)
      $display("FAIL single latency: got lvl=%0d tx=%b want 0 0", fifo_level, cac_uart_tx);
    else n_pass++;
    run_frame(1'b0, 8'h10, 0, "single", nl);
    n_checks++;
    if (nl || tx_busy !== 1'b0) $display("FAIL single end: got low=%b busy=%b want 0 0", nl, tx_busy);
    else n_pass++;
  endtask

  task automatic test_burst();
    logic [7:0] b [5] = '{8'h10, 8'h01, 8'h11, 8'h11, 8'h30};
    int not_ready = 0;
    int start_cyc;
    bit nl;
    for (int i = 0; i < 5; i++) begin
      tx_data = b[i]; tx_valid = 1'b1;
      if (tx_ready !== 1'b1) not_ready++;
      tick();
      if (i == 1) start_cyc = cyc;
    end
    tx_valid = 1'b0;
    n_checks++;
    if (not_ready != 0) $display("FAIL burst accept: %0d refused pushes, want 0", not_ready);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 3'd4 || tx_ready !== 1'b0)
      $display("FAIL burst full: got lvl=%0d rdy=%b want 4 0", fifo_level, tx_ready);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b0, b[i], (i == 0) ? 3 : 0, "burst", nl);
      n_checks++;
      if (nl !== (i < 4)) $display("FAIL burst gap %0d: got next_low=%b want %b", i, nl, i < 4);
      else n_pass++;
    end
    n_checks++;
    if (cyc - start_cyc != 500) $display("FAIL burst length: got %0d want 500", cyc - start_cyc);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    int fall_cyc;
    int leaked = 0;
    int budget = 0;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_data = 8'h01;
    tick();
    fall_cyc = cyc;
    tx_data = 8'h02; tick();
    tx_data = 8'h03; tick();
    tx_data = 8'h04; tick();
    tx_data = 8'h06;
    while (cyc < fall_cyc + 99) begin
      if (tx_ready !== 1'b0 || fifo_level !== 3'd4) leaked++;
      tick();
    end
    n_checks++;
    if (leaked != 0 || fifo_level !== 3'd4)
      $display("FAIL full hold: %0d bad cycles lvl=%0d, want 0 and 4", leaked, fifo_level);
    else n_pass++;
    tick();
    n_checks++;
    if (fifo_level !== 3'd3 || tx_ready !== 1'b1 || cac_uart_tx !== 1'b0)
      $display("FAIL full pop edge: got lvl=%0d rdy=%b tx=%b want 3 1 0",
               fifo_level, tx_ready, cac_uart_tx);
    else n_pass++;
    tick();
    tx_valid = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd4 || tx_ready !== 1'b0)
      $display("FAIL full late push: got lvl=%0d rdy=%b want 4 0", fifo_level, tx_ready);
    else n_pass++;
    while (tx_busy === 1'b1 && budget < 700) begin
      tick();
      budget++;
    end
    n_checks++;
    if (tx_busy !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL full drain: got busy=%b lvl=%0d want 0 0", tx_busy, fifo_level);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int fall_cyc;
    int bad = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_data = 8'h11;
    tick();
    fall_cyc = cyc;
    tx_data = 8'h22;
    tick();
    tx_valid = 1'b0;
    while (cyc < fall_cyc + 45) tick();
    n_checks++;
    if (cac_uart_tx !== 1'b0 || fifo_level !== 3'd2)
      $display("FAIL mid bit4: got tx=%b lvl=%0d want 0 2", cac_uart_tx, fifo_level);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({cac_uart_tx, tx_ready, tx_busy, frame_done, fifo_level} !== 7'b1100_000)
      $display("FAIL mid async reset: got tx=%b rdy=%b busy=%b done=%b lvl=%0d want 1 1 0 0 0",
               cac_uart_tx, tx_ready, tx_busy, frame_done, fifo_level);
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cac_uart_tx !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL mid after release: %0d active cycles, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_two_stop();
    bit nl;
    tx_data2 = 8'hFF; tx_valid2 = 1'b1;
    tick();
    tick();
    tx_valid2 = 1'b0;
    n_checks++;
    if (tx2 !== 1'b0 || level2 !== 3'd1)
      $display("FAIL two_stop start: got tx=%b lvl=%0d want 0 1", tx2, level2);
    else n_pass++;
    run_frame(1'b1, 8'hFF, 0, "two_stop_a", nl);
    n_checks++;
    if (!nl) $display("FAIL two_stop next fall at 110: got line high, want low");
    else n_pass++;
    run_frame(1'b1, 8'hFF, 0, "two_stop_b", nl);
    n_checks++;
    if (nl || busy2 !== 1'b0) $display("FAIL two_stop end: got low=%b busy=%b want 0 0", nl, busy2);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    tx_data2 = '0; tx_valid2 = 1'b0;
    test_reset();
    test_line_idle();
    test_single();
    test_burst();
    test_full_pop();
    test_reset_mid();
    test_two_stop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
